// File: rtl/tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tx_scheduler
//  Purpose  : Shares one serial byte transmitter among NREQ byte-stream
//             requesters. Ownership is granted round-robin and held for a
//             whole message (terminated by the byte flagged req_last). Each
//             accepted byte is issued as a one-cycle tx_start with tx_data
//             held stable; the next byte waits for both a minimum start-to-
//             start gap and an idle transmitter. A granted requester that
//             stops offering data for too long loses its grant.
//  Ports    :
//    sysclk       in   1        system clock
//    rst          in   1        synchronous active-high reset
//    req_valid    in   NREQ     requester i offers a byte
//    req_data     in   8*NREQ   packed bytes, requester 0 in [7:0]
//    req_last     in   NREQ     offered byte is the last of its message
//    req_ready    out  NREQ     byte accepted when req_valid & req_ready
//    grant        out  NREQ     one-hot transmitter owner, zero when idle
//    tx_start     out  1        one-cycle start pulse to the transmitter
//    tx_data      out  8        byte to transmit, held until next accept
//    tx_busy      in   1        transmitter is shifting a frame
//    stall_abort  out  1        one-cycle pulse when a message is dropped
//  Revision : 1.0  initial release
// ============================================================================
module tx_scheduler #(
    parameter int NREQ       = 2,
    parameter int GAP_CYCLES = 78105,
    parameter int STALL_MAX  = 1023,
    parameter int CW         = 17
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              stall_abort
);

    localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_STL_W = $clog2(STALL_MAX + 1);

    localparam logic [CW-1:0]      c_GAP_END   = CW'(GAP_CYCLES - 1);
    localparam logic [c_STL_W-1:0] c_STALL_END = c_STL_W'(STALL_MAX - 1);
    localparam logic [c_PTR_W-1:0] c_LAST_IDX  = c_PTR_W'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [NREQ-1:0]      r_grant;
    logic [c_PTR_W-1:0]   r_owner;      // index of the granted requester
    logic [c_PTR_W-1:0]   r_rr_ptr;     // where the next search begins
    logic                 r_last;       // current byte closes the message
    logic [c_STL_W-1:0]   r_stall_cnt;
    logic [CW-1:0]        r_gap_cnt;
    logic                 r_tx_start;
    logic [7:0]           r_tx_data;
    logic                 r_stall_abort;

    // ------------------------------------------------------------------
    // Round-robin search starting at r_rr_ptr, wrapping modulo NREQ
    // ------------------------------------------------------------------
    logic                 w_hit;
    logic [c_PTR_W-1:0]   w_hit_idx;
    logic [c_PTR_W-1:0]   w_cand;
    int                   w_sum;
    logic [NREQ-1:0]      w_hit_onehot;

    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_cand    = '0;
        w_sum     = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_sum = int'(r_rr_ptr) + i;
            if (w_sum >= NREQ) begin
                w_sum = w_sum - NREQ;
            end
            w_cand = c_PTR_W'(w_sum);
            if (!w_hit && req_valid[w_cand]) begin
                w_hit     = 1'b1;
                w_hit_idx = w_cand;
            end
        end
    end

    assign w_hit_onehot = NREQ'(1) << w_hit_idx;

    // ------------------------------------------------------------------
    // Owner's byte / flags selected through the one-hot grant
    // ------------------------------------------------------------------
    logic [7:0] w_masked_data [NREQ];
    logic [7:0] w_sel_data;
    logic       w_sel_last;
    logic       w_accept;

    for (genvar g = 0; g < NREQ; g++) begin : g_data_mask
        assign w_masked_data[g] = req_data[8*g +: 8] & {8{r_grant[g]}};
    end

    always_comb begin
        w_sel_data = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            w_sel_data = w_sel_data | w_masked_data[i];
        end
    end

    // Only the owner's valid/last matter; everyone else is ignored.
    assign w_sel_last = |(req_last & r_grant);
    assign w_accept   = |(req_valid & r_grant);

    // Pointer to the requester after the current owner.
    logic [c_PTR_W-1:0] w_next_ptr;
    assign w_next_ptr = (r_owner == c_LAST_IDX) ? '0 : (r_owner + c_PTR_W'(1));

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_owner       <= '0;
            r_rr_ptr      <= '0;
            r_last        <= 1'b0;
            r_stall_cnt   <= '0;
            r_gap_cnt     <= '0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= 8'h00;
            r_stall_abort <= 1'b0;
        end else begin
            // Pulses default low; set only on the transition that owns them.
            r_tx_start    <= 1'b0;
            r_stall_abort <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_hit) begin
                        r_grant     <= w_hit_onehot;
                        r_owner     <= w_hit_idx;
                        r_stall_cnt <= '0;
                        r_state     <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (w_accept) begin
                        r_tx_data   <= w_sel_data;
                        r_last      <= w_sel_last;
                        r_stall_cnt <= '0;
                        // Registered so the pulse lines up with ST_START.
                        r_tx_start  <= 1'b1;
                        r_state     <= ST_START;
                    end else if (r_stall_cnt == c_STALL_END) begin
                        r_stall_abort <= 1'b1;
                        r_grant       <= '0;
                        r_rr_ptr      <= w_next_ptr;
                        r_stall_cnt   <= '0;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_stall_cnt <= r_stall_cnt + c_STL_W'(1);
                    end
                end

                ST_START: begin
                    // The START cycle itself is the first cycle of the gap.
                    r_gap_cnt <= CW'(1);
                    r_state   <= ST_GAP;
                end

                ST_GAP: begin
                    if (r_gap_cnt < c_GAP_END) begin
                        r_gap_cnt <= r_gap_cnt + CW'(1);
                    end
                    // A busy transmitter holds us here indefinitely.
                    if ((r_gap_cnt >= c_GAP_END) && !tx_busy) begin
                        if (r_last) begin
                            r_grant  <= '0;
                            r_rr_ptr <= w_next_ptr;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_state  <= ST_LOAD;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready   = (r_state == ST_LOAD) ? r_grant : '0;
    assign grant       = r_grant;
    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign stall_abort = r_stall_abort;

endmodule
`default_nettype wire

// File: tb/tb_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tx_scheduler
//  Purpose  : Directed self-checking bench for tx_scheduler with
//             GAP_CYCLES=8, STALL_MAX=16, NREQ=2.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tx_scheduler;

    localparam int NREQ = 2;
    localparam int GAP  = 8;
    localparam int SMAX = 16;
    localparam int CWID = 4;

    logic            sysclk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid;
    logic [15:0]     req_data;
    logic [1:0]      req_last;
    logic [1:0]      req_ready;
    logic [1:0]      grant;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic            tx_busy;
    logic            stall_abort;

    tx_scheduler #(
        .NREQ       (NREQ),
        .GAP_CYCLES (GAP),
        .STALL_MAX  (SMAX),
        .CW         (CWID)
    ) dut (
        .sysclk      (sysclk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .grant       (grant),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .stall_abort (stall_abort)
    );

    always #5 sysclk = ~sysclk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Requester message queues
    logic [7:0] q_data [2][16];
    logic       q_last [2][16];
    int         q_n   [2];
    int         q_idx [2];
    int         busy_len;
    int         busy_left;

    // Observation logs
    int         st_cyc   [$];
    logic [7:0] st_data  [$];
    logic [1:0] st_grant [$];
    int         ab_cyc   [$];

    task automatic tick();
        @(posedge sysclk);
        #1;
        cyc++;
    endtask

    // One cycle: present requester bytes, model tx_busy, log outputs.
    task automatic step();
        logic [1:0] acc;
        for (int i = 0; i < 2; i++) begin
            if (q_idx[i] < q_n[i]) begin
                req_valid[i]        = 1'b1;
                req_data[8*i +: 8]  = q_data[i][q_idx[i]];
                req_last[i]         = q_last[i][q_idx[i]];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[8*i +: 8]  = 8'h00;
                req_last[i]         = 1'b0;
            end
        end
        tx_busy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
        if (tx_start === 1'b1) begin
            st_cyc.push_back(cyc);
            st_data.push_back(tx_data);
            st_grant.push_back(grant);
            busy_left = busy_len;
        end
        if (stall_abort === 1'b1) ab_cyc.push_back(cyc);
        acc = req_valid & req_ready;
        tick();
        for (int i = 0; i < 2; i++) begin
            if (acc[i]) q_idx[i]++;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 2'b00;
        req_data  = 16'h0000;
        req_last  = 2'b00;
        tx_busy   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            q_n[i]   = 0;
            q_idx[i] = 0;
        end
        busy_left = 0;
        busy_len  = 3;
        tick();
        tick();
        rst = 1'b0;
        st_cyc.delete();
        st_data.delete();
        st_grant.delete();
        ab_cyc.delete();
        cyc = 0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 2'b11;
        req_data  = 16'h4241;
        req_last  = 2'b00;
        tx_busy   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (grant !== 2'b00) begin
                n_fail++; $display("FAIL reset_grant cyc%0d: got %b expected 00", i, grant);
            end
            n_checks++;
            if (tx_start !== 1'b0) begin
                n_fail++; $display("FAIL reset_tx_start cyc%0d: got %b expected 0", i, tx_start);
            end
            n_checks++;
            if (tx_data !== 8'h00) begin
                n_fail++; $display("FAIL reset_tx_data cyc%0d: got %h expected 00", i, tx_data);
            end
            n_checks++;
            if (req_ready !== 2'b00) begin
                n_fail++; $display("FAIL reset_req_ready cyc%0d: got %b expected 00", i, req_ready);
            end
            n_checks++;
            if (stall_abort !== 1'b0) begin
                n_fail++; $display("FAIL reset_stall_abort cyc%0d: got %b expected 0", i, stall_abort);
            end
        end
        rst = 1'b0;
        // Arbitration cycle: still no grant, no ready.
        n_checks++;
        if (grant !== 2'b00 || req_ready !== 2'b00) begin
            n_fail++; $display("FAIL reset_arb_cycle: got grant %b ready %b expected 00 00", grant, req_ready);
        end
        tick();
        n_checks++;
        if (grant !== 2'b01) begin
            n_fail++; $display("FAIL reset_first_grant: got %b expected 01", grant);
        end
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL reset_first_ready: got %b expected 01", req_ready);
        end
        tick();
        n_checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h41) begin
            n_fail++; $display("FAIL reset_first_start: got start %b data %h expected 1 41", tx_start, tx_data);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_message();
        do_reset();
        q_data[0][0] = 8'h48; q_last[0][0] = 1'b0;
        q_data[0][1] = 8'h49; q_last[0][1] = 1'b1;
        q_n[0] = 2;
        for (int i = 0; i < 40; i++) step();
        n_checks++;
        if (st_cyc.size() != 2) begin
            n_fail++; $display("FAIL single_start_count: got %0d expected 2", st_cyc.size());
        end
        if (st_cyc.size() >= 2) begin
            n_checks++;
            if (st_data[0] !== 8'h48 || st_data[1] !== 8'h49) begin
                n_fail++; $display("FAIL single_data: got %h %h expected 48 49", st_data[0], st_data[1]);
            end
            n_checks++;
            if (st_cyc[1] - st_cyc[0] != 9) begin
                n_fail++; $display("FAIL single_spacing: got %0d expected 9", st_cyc[1] - st_cyc[0]);
            end
            n_checks++;
            if (st_grant[0] !== 2'b01 || st_grant[1] !== 2'b01) begin
                n_fail++; $display("FAIL single_grant: got %b %b expected 01 01", st_grant[0], st_grant[1]);
            end
        end
        n_checks++;
        if (grant !== 2'b00) begin
            n_fail++; $display("FAIL single_release: got %b expected 00", grant);
        end
        n_checks++;
        if (tx_data !== 8'h49) begin
            n_fail++; $display("FAIL single_data_hold: got %h expected 49", tx_data);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_round_robin();
        logic [7:0] exp_d [8];
        logic [1:0] exp_g [8];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q_data[0][i] = 8'hA0 + 8'(i); q_last[0][i] = i[0];
            q_data[1][i] = 8'hB0 + 8'(i); q_last[1][i] = i[0];
        end
        q_n[0] = 4;
        q_n[1] = 4;
        exp_d = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA2, 8'hA3, 8'hB2, 8'hB3};
        exp_g = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
        for (int i = 0; i < 120; i++) step();
        n_checks++;
        if (st_cyc.size() != 8) begin
            n_fail++; $display("FAIL rr_start_count: got %0d expected 8", st_cyc.size());
        end
        for (int k = 0; k < 8; k++) begin
            if (k < st_cyc.size()) begin
                n_checks++;
                if (st_data[k] !== exp_d[k] || st_grant[k] !== exp_g[k]) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: got data %h grant %b expected %h %b",
                             k, st_data[k], st_grant[k], exp_d[k], exp_g[k]);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_busy_extension();
        do_reset();
        busy_len = 20;
        q_data[0][0] = 8'h11; q_last[0][0] = 1'b0;
        q_data[0][1] = 8'h12; q_last[0][1] = 1'b1;
        q_n[0] = 2;
        for (int i = 0; i < 60; i++) step();
        n_checks++;
        if (st_cyc.size() != 2) begin
            n_fail++; $display("FAIL busy_start_count: got %0d expected 2", st_cyc.size());
        end
        if (st_cyc.size() >= 2) begin
            // busy high start+1..start+20, low at start+21 -> LOAD, START
            n_checks++;
            if (st_cyc[1] - st_cyc[0] != 23) begin
                n_fail++; $display("FAIL busy_spacing: got %0d expected 23", st_cyc[1] - st_cyc[0]);
            end
            n_checks++;
            if (st_data[1] !== 8'h12) begin
                n_fail++; $display("FAIL busy_data: got %h expected 12", st_data[1]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_stall();
        logic [7:0] exp_d [4];
        logic [1:0] exp_g [4];
        do_reset();
        q_data[1][0] = 8'h55; q_last[1][0] = 1'b0;
        q_n[1] = 1;
        exp_d = '{8'h55, 8'hA1, 8'hA2, 8'hC1};
        exp_g = '{2'b10, 2'b01, 2'b01, 2'b10};
        for (int i = 0; i < 80; i++) begin
            // req0 becomes valid during req1's message: must not preempt.
            if (st_cyc.size() >= 1 && q_n[0] == 0) begin
                q_data[0][0] = 8'hA1; q_last[0][0] = 1'b0;
                q_data[0][1] = 8'hA2; q_last[0][1] = 1'b1;
                q_n[0] = 2;
            end
            // req1 competes again right at the abort: rr_ptr must favour req0.
            if (stall_abort === 1'b1 && q_n[1] == 1) begin
                q_data[1][1] = 8'hC1; q_last[1][1] = 1'b1;
                q_n[1] = 2;
            end
            step();
        end
        n_checks++;
        if (ab_cyc.size() != 1) begin
            n_fail++; $display("FAIL stall_abort_count: got %0d expected 1", ab_cyc.size());
        end
        if (ab_cyc.size() >= 1 && st_cyc.size() >= 1) begin
            n_checks++;
            if (ab_cyc[0] - st_cyc[0] != 24) begin
                n_fail++; $display("FAIL stall_abort_time: got %0d expected 24", ab_cyc[0] - st_cyc[0]);
            end
        end
        n_checks++;
        if (st_cyc.size() != 4) begin
            n_fail++; $display("FAIL stall_start_count: got %0d expected 4", st_cyc.size());
        end
        for (int k = 0; k < 4; k++) begin
            if (k < st_cyc.size()) begin
                n_checks++;
                if (st_data[k] !== exp_d[k] || st_grant[k] !== exp_g[k]) begin
                    n_fail++;
                    $display("FAIL stall_order[%0d]: got data %h grant %b expected %h %b",
                             k, st_data[k], st_grant[k], exp_d[k], exp_g[k]);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_mid_reset();
        int guard;
        int rel_cyc;
        do_reset();
        // Single-byte message from req0 moves rr_ptr to 1.
        q_data[0][0] = 8'hE0; q_last[0][0] = 1'b1;
        q_n[0] = 1;
        for (int i = 0; i < 15; i++) step();
        for (int i = 0; i < 4; i++) begin
            q_data[1][i] = 8'hD0 + 8'(i); q_last[1][i] = (i == 3);
        end
        q_n[1] = 4;
        guard = 0;
        while (st_cyc.size() < 3 && guard < 60) begin
            step();
            guard++;
        end
        n_checks++;
        if (st_cyc.size() != 3) begin
            n_fail++; $display("FAIL midrst_prefix_starts: got %0d expected 3", st_cyc.size());
        end
        for (int i = 0; i < 3; i++) step();   // now inside the gap of D1
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            q_n[i] = 0; q_idx[i] = 0;
        end
        busy_left = 0;
        step();
        step();
        rst = 1'b0;
        rel_cyc = cyc;
        q_data[0][0] = 8'hF0; q_last[0][0] = 1'b0;
        q_data[0][1] = 8'hF1; q_last[0][1] = 1'b1;
        q_data[1][0] = 8'h60; q_last[1][0] = 1'b0;
        q_data[1][1] = 8'h61; q_last[1][1] = 1'b1;
        q_n[0] = 2;
        q_n[1] = 2;
        for (int i = 0; i < 40; i++) step();
        n_checks++;
        if (st_cyc.size() < 4) begin
            n_fail++; $display("FAIL midrst_restart: got %0d starts expected at least 4", st_cyc.size());
        end else begin
            n_checks++;
            if (st_cyc[3] - rel_cyc != 2) begin
                n_fail++; $display("FAIL midrst_first_start_time: got %0d expected 2", st_cyc[3] - rel_cyc);
            end
            n_checks++;
            if (st_data[3] !== 8'hF0 || st_grant[3] !== 2'b01) begin
                n_fail++; $display("FAIL midrst_rr_restart: got data %h grant %b expected F0 01",
                                   st_data[3], st_grant[3]);
            end
        end
        for (int k = 0; k < st_data.size(); k++) begin
            n_checks++;
            if (st_data[k] === 8'hD2 || st_data[k] === 8'hD3) begin
                n_fail++; $display("FAIL midrst_abandoned[%0d]: got %h expected not D2/D3", k, st_data[k]);
            end
        end
        n_checks++;
        if (ab_cyc.size() != 0) begin
            n_fail++; $display("FAIL midrst_stall_abort: got %0d pulses expected 0", ab_cyc.size());
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_single_message();
        test_round_robin();
        test_busy_extension();
        test_stall();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
